// File: rtl/mu_cgra_pkg.sv
// Shared lane/word types for the matrix-unit <-> CGRA stream blocks.
package mu_cgra_pkg;

  localparam int unsigned MU_NUM_LANES  = 32;
  localparam int unsigned MU_DATA_WIDTH = 16;

  typedef logic [15:0] mu_lane_t;
  typedef mu_lane_t [MU_NUM_LANES-1:0] mu_word_t;

endpackage

// File: rtl/mu2cgra_rx_lane_track.sv
// Per-lane consumption tracking for the head word: done vector, lane valids, retire pulse.
module mu2cgra_rx_lane_track #(
  parameter int unsigned NUM_LANES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 head_valid,
  input  logic [NUM_LANES-1:0] lane_ready,
  output logic [NUM_LANES-1:0] lane_valid,
  output logic                 pop
);

  logic [NUM_LANES-1:0] done;
  logic [NUM_LANES-1:0] fire;

  always_comb begin
    lane_valid = head_valid ? ~done : '0;
    fire       = lane_valid & lane_ready;
    pop        = head_valid && (&(done | fire));
  end

  // The last outstanding lane's fire retires the word in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= '0;
    end else if (flush || pop) begin
      done <= '0;
    end else begin
      done <= done | fire;
    end
  end

endmodule

// File: rtl/mu2cgra_rx.sv
// MU->CGRA receive FIFO with per-lane retire tracking.
// Optional statistics counters enabled by defining MU2CGRA_RX_STATS_EN.
module mu2cgra_rx
  import mu_cgra_pkg::*;
#(
  parameter int unsigned NUM_LANES  = MU_NUM_LANES,
  parameter int unsigned DATA_WIDTH = MU_DATA_WIDTH,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  flush,
  input  logic                  mu2cgra_valid,
  output logic                  cgra2mu_ready,
  input  logic [DATA_WIDTH-1:0] mu2cgra [NUM_LANES],
  output logic [DATA_WIDTH-1:0] lane_dat [NUM_LANES],
  output logic [NUM_LANES-1:0]  lane_valid,
  input  logic [NUM_LANES-1:0]  lane_ready,
  output logic [31:0]           stat_words,
  output logic [31:0]           stat_stalls
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH][NUM_LANES];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [PTR_W:0]        count;
  logic                  head_valid;
  logic                  push;
  logic                  pop;

  assign cgra2mu_ready = (count != FULL);
  assign head_valid    = (count != '0);
  assign push          = mu2cgra_valid && cgra2mu_ready && !flush;

  always_comb begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      lane_dat[i] = mem[rptr][i];
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wptr] <= mu2cgra;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  mu2cgra_rx_lane_track #(
    .NUM_LANES(NUM_LANES)
  ) u_lane_track (
    .clk        (clk_in),
    .rst        (reset_in),
    .flush      (flush),
    .head_valid (head_valid),
    .lane_ready (lane_ready),
    .lane_valid (lane_valid),
    .pop        (pop)
  );

`ifdef MU2CGRA_RX_STATS_EN
  logic [31:0] words_q;
  logic [31:0] stalls_q;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      words_q  <= '0;
      stalls_q <= '0;
    end else if (flush) begin
      words_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (push) words_q <= words_q + 1'b1;
      if (mu2cgra_valid && !cgra2mu_ready) stalls_q <= stalls_q + 1'b1;
    end
  end

  assign stat_words  = words_q;
  assign stat_stalls = stalls_q;
`else
  assign stat_words  = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_mu2cgra_rx.sv
// Self-checking bench for mu2cgra_rx: vector table, hand sequences, queue scoreboard.
module tb_mu2cgra_rx;
  import mu_cgra_pkg::*;

  localparam int NL = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset_in = 1'b1;
  logic            flush = 1'b0;
  logic            mu2cgra_valid = 1'b0;
  logic            cgra2mu_ready;
  logic [15:0]     mu2cgra [NL];
  logic [15:0]     lane_dat [NL];
  logic [NL-1:0]   lane_valid;
  logic [NL-1:0]   lane_ready = '0;
  logic [31:0]     stat_words;
  logic [31:0]     stat_stalls;

  int n_checks = 0;
  int n_fail = 0;

  mu2cgra_rx #(
    .NUM_LANES(NL),
    .DATA_WIDTH(16),
    .DEPTH(DEPTH)
  ) dut (
    .clk_in        (clk),
    .reset_in      (reset_in),
    .flush         (flush),
    .mu2cgra_valid (mu2cgra_valid),
    .cgra2mu_ready (cgra2mu_ready),
    .mu2cgra       (mu2cgra),
    .lane_dat      (lane_dat),
    .lane_valid    (lane_valid),
    .lane_ready    (lane_ready),
    .stat_words    (stat_words),
    .stat_stalls   (stat_stalls)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  task automatic drive(input bit v, input logic [15:0] base, input logic [NL-1:0] rdy, input bit fl);
    @(posedge clk);
    #1;
    mu2cgra_valid = v;
    for (int i = 0; i < NL; i++) mu2cgra[i] = base + 16'(i + 1);
    lane_ready = rdy;
    flush = fl;
  endtask

  // Scoreboard: expected words queued at predicted push, checked lane by lane as they fire.
  mu_word_t       sb [$];
  logic [NL-1:0]  m_done = '0;
  logic [NL-1:0]  m_valid;
  logic [NL-1:0]  m_fire;
  logic           m_ready;
  logic [31:0]    m_words = 0;
  logic [31:0]    m_stalls = 0;
  mu_word_t       w;

  always @(negedge clk) begin
    if (reset_in) begin
      sb.delete();
      m_done = '0;
      m_words = 0;
      m_stalls = 0;
      check("reset_ready", {31'd0, cgra2mu_ready}, 32'd1);
      check("reset_valid", lane_valid, 32'd0);
    end else begin
      m_ready = (sb.size() != DEPTH);
      for (int i = 0; i < NL; i++) m_valid[i] = (sb.size() != 0) && !m_done[i];
      check("ready", {31'd0, cgra2mu_ready}, {31'd0, m_ready});
      check("lane_valid", lane_valid, m_valid);
`ifdef MU2CGRA_RX_STATS_EN
      check("stat_words", stat_words, m_words);
      check("stat_stalls", stat_stalls, m_stalls);
`else
      check("stat_words_tied", stat_words, 32'd0);
      check("stat_stalls_tied", stat_stalls, 32'd0);
`endif
      m_fire = m_valid & lane_ready;
      for (int i = 0; i < NL; i++)
        if (m_fire[i]) check($sformatf("lane_dat[%0d]", i), {16'd0, lane_dat[i]}, {16'd0, sb[0][i]});
      if (flush) begin
        sb.delete();
        m_done = '0;
        m_words = 0;
        m_stalls = 0;
      end else begin
        if (sb.size() != 0 && (&(m_done | m_fire))) begin
          void'(sb.pop_front());
          m_done = '0;
        end else begin
          m_done = m_done | m_fire;
        end
        if (mu2cgra_valid && m_ready) begin
          for (int i = 0; i < NL; i++) w[i] = mu2cgra[i];
          sb.push_back(w);
          m_words = m_words + 1;
        end
        if (mu2cgra_valid && !m_ready) m_stalls = m_stalls + 1;
      end
    end
  end

  typedef struct {
    bit          v;
    logic [15:0] base;
    logic [31:0] rdy;
    bit          exp_ready;
    logic [31:0] exp_valid;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [NL-1:0] m;
    logic [NL-1:0] ev;

    for (int i = 0; i < NL; i++) mu2cgra[i] = '0;
    vecs[0]  = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
    vecs[1]  = '{1'b1, 16'h0100, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};
    vecs[2]  = '{1'b0, 16'h0000, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};
    vecs[3]  = '{1'b0, 16'h0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
    vecs[4]  = '{1'b1, 16'h0200, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[5]  = '{1'b1, 16'h0300, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF};
    vecs[6]  = '{1'b1, 16'h0400, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF};
    vecs[7]  = '{1'b1, 16'h0500, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF};
    vecs[8]  = '{1'b1, 16'h0600, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF};
    vecs[9]  = '{1'b1, 16'h0600, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF};
    vecs[10] = '{1'b1, 16'h0600, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF};

    repeat (3) @(posedge clk);
    #1 reset_in = 1'b0;

    // Back-to-back words, then fill the FIFO with all lanes stalled.
    for (int k = 0; k < 11; k++) begin
      drive(vecs[k].v, vecs[k].base, vecs[k].rdy, 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d_ready", k), {31'd0, cgra2mu_ready}, {31'd0, vecs[k].exp_ready});
      check($sformatf("vec%0d_valid", k), lane_valid, vecs[k].exp_valid);
      if (k == 1) check("vecA_lane0", {16'd0, lane_dat[0]}, 32'h0001);
      if (k == 1) check("vecA_lane31", {16'd0, lane_dat[31]}, 32'h0020);
      if (k == 2) check("vecB_lane0", {16'd0, lane_dat[0]}, 32'h0101);
    end

    // One more lane ready per cycle while the MU keeps offering a word to a full FIFO.
    m = '0;
    for (int j = 0; j < NL; j++) begin
      m[j] = 1'b1;
      drive(1'b1, 16'h0600, m, 1'b0);
      @(negedge clk);
      ev = '1;
      ev = ev << j;
      check($sformatf("step%0d_valid", j), lane_valid, ev);
      check($sformatf("step%0d_ready", j), {31'd0, cgra2mu_ready}, 32'd0);
    end
    drive(1'b1, 16'h0600, '0, 1'b0);
    @(negedge clk);
    check("after_retire_valid", lane_valid, 32'hFFFF_FFFF);
    check("after_retire_ready", {31'd0, cgra2mu_ready}, 32'd1);
    check("after_retire_head", {16'd0, lane_dat[0]}, 32'h0301);
    drive(1'b0, 16'h0000, '0, 1'b0);
    @(negedge clk);
    check("refull_ready", {31'd0, cgra2mu_ready}, 32'd0);
    repeat (6) drive(1'b0, 16'h0000, '1, 1'b0);
    for (int k = 0; k < 6; k++) drive(1'b1, 16'h0700 + 16'(k * 256), '1, 1'b0);
    repeat (3) drive(1'b0, 16'h0000, '1, 1'b0);

    for (int k = 0; k < 40; k++)
      drive(1'($urandom_range(0, 1)), 16'h4000 + 16'(k * 64), NL'($urandom), 1'b0);
    repeat (8) drive(1'b0, 16'h0000, '1, 1'b0);

    // Flush with three words buffered and the head half consumed.
    drive(1'b1, 16'h1000, '0, 1'b0);
    drive(1'b1, 16'h1100, '0, 1'b0);
    drive(1'b1, 16'h1200, '0, 1'b0);
    drive(1'b0, 16'h0000, 32'h0000_FFFF, 1'b0);
    drive(1'b1, 16'h1300, '0, 1'b1);
    @(negedge clk);
    check("flush_cycle_valid", lane_valid, 32'hFFFF_0000);
    drive(1'b0, 16'h0000, '0, 1'b0);
    @(negedge clk);
    check("post_flush_valid", lane_valid, 32'd0);
    check("post_flush_ready", {31'd0, cgra2mu_ready}, 32'd1);
    drive(1'b1, 16'h1400, '0, 1'b0);
    drive(1'b0, 16'h0000, '0, 1'b0);
    @(negedge clk);
    check("post_flush_push_valid", lane_valid, 32'hFFFF_FFFF);
    check("post_flush_lane0", {16'd0, lane_dat[0]}, 32'h1401);
    check("post_flush_lane31", {16'd0, lane_dat[31]}, 32'h1420);
    repeat (3) drive(1'b0, 16'h0000, '1, 1'b0);

    // Asynchronous reset in the middle of a stream.
    drive(1'b1, 16'h2000, '0, 1'b0);
    drive(1'b1, 16'h2100, '0, 1'b0);
    @(posedge clk);
    #3;
    reset_in = 1'b1;
    mu2cgra_valid = 1'b0;
    #1;
    check("async_reset_ready", {31'd0, cgra2mu_ready}, 32'd1);
    check("async_reset_valid", lane_valid, 32'd0);
    check("async_reset_words", stat_words, 32'd0);
    check("async_reset_stalls", stat_stalls, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_in = 1'b0;
    drive(1'b1, 16'h2200, '1, 1'b0);
    drive(1'b1, 16'h2300, '1, 1'b0);
    @(negedge clk);
    check("resume_lane0", {16'd0, lane_dat[0]}, 32'h2201);
    repeat (3) drive(1'b0, 16'h0000, '1, 1'b0);
    @(negedge clk);
    check("final_valid", lane_valid, 32'd0);
    check("final_ready", {31'd0, cgra2mu_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
